conv_input_word_buf_writer: RTL
===============================

Name: conv_input_word_buf_writer

Overview:
- Consumes the 512-bit DDR read-data stream returned for the conv input-load commands.
- Pairs each word with the per-word load-info entry (row-buffer index, row-buffer address) that the input-load DDR controller pushed into the load-input info FIFO.
- Issues the registered write into the selected input row buffer.
- Counts words, flags protocol errors, and pulses a completion signal when the programmed word total has been written.

Parameters:
- DATA_W, 512, DDR/buffer word width
- BUFFERS_NUM, 3, number of input row buffers
- BUF_IDX_W, 2, width of the buffer index output
- BUF_ADR_W, 16, buffer address width; must satisfy BUF_ADR_W ≤ 16
- INFO_W, 32, info FIFO word width: [31:16] buffer idx, [15:0] buffer address

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: arm for a new load term
- total_words  input  16  words expected this term; sampled on start
- ddr_rd_data  input  DATA_W  DDR read word
- ddr_rd_data_valid  input  1  ddr_rd_data valid this cycle
- info_fifo_empty  input  1  load-info FIFO empty
- info_fifo_dout  input  INFO_W  load-info FIFO output (standard FIFO, 1-cycle read latency)
- info_fifo_rd_en  output  1  load-info FIFO pop
- input_word_buf_en_wr  output  BUFFERS_NUM  one-hot row-buffer write enable
- input_word_buf_idx_wr  output  BUF_IDX_W  target buffer index
- input_word_buf_adr_wr  output  BUF_ADR_W  target buffer address
- input_word_buf_wr  output  DATA_W  write data
- words_written  output  16  words written this term
- busy  output  1  high in RUN or DRAIN
- load_fin  output  1  one-cycle pulse when the term completes
- err_underflow  output  1  sticky: data arrived while info FIFO empty
- err_bad_idx  output  1  sticky: info entry buffer idx ≥ BUFFERS_NUM

Behaviour:
- Reset (reset==0, async): all outputs 0; FSM state IDLE; internal pipeline valid bits and counters 0.
- FSM states:
  - IDLE: start → RUN, latching total_words and clearing words_written and both error flags. If total_words==0, go to DONE instead.
  - RUN: accept words.
  - DRAIN: entered when the accepted count reaches the latched total; waits until the pipeline is empty.
  - DONE: lasts one cycle, load_fin=1, then IDLE.
- Accept (RUN only): accept = ddr_rd_data_valid & ~info_fifo_empty & (accepted_cnt < total).
  - info_fifo_rd_en = accept, combinational.
  - Stage 1 registers the data and the valid bit.
- Stage 2, cycle N+1: info_fifo_dout is valid. The outputs register data, idx = dout[16+:BUF_IDX_W] and adr = dout[0+:BUF_ADR_W].
  - input_word_buf_en_wr = 1<<idx if idx < BUFFERS_NUM.
  - Otherwise en=0 and err_bad_idx is set; the word is still counted.
- Latency: a word accepted at edge N drives the buffer write outputs during cycle N+2. Throughput is 1 word/cycle, with no bubbles under continuous valid.
- Write outputs are valid for exactly one cycle per word. When not writing, en=0 and data, idx and adr hold 0.
- words_written increments, saturating at 16 bits, on each stage-2 issue (including bad-idx drops).
- Transition to DRAIN: the cycle after the accept that makes accepted_cnt==total. DRAIN → DONE when stage 1 and stage 2 are both empty, so load_fin asserts in the cycle after the last write cycle.
- Underflow: ddr_rd_data_valid & info_fifo_empty in RUN:
  - the word is dropped (not accepted) and err_underflow is set;
  - the FSM stays in RUN.
- Data outside a term: ddr_rd_data_valid in IDLE, DRAIN or DONE is ignored and produces no FIFO pop.
- Back-to-back terms: start in DONE or IDLE is honoured. start in RUN or DRAIN is ignored.
- Errors stay sticky until the next accepted start or reset.
- Async reset mid-term: output enables drop immediately, the pipeline is discarded, and the FSM returns to IDLE. The info FIFO is reset separately by the system.

Test Plan:
- Basic run: start with total_words=4; info entries {0,0x10},{1,0x10},{2,0x10},{0,0x11}; valid high 4 cycles with data 1..4.
  - en = 001,010,100,001 with adr 0x10,0x10,0x10,0x11 and data 1..4 in cycles N+2..N+5.
  - load_fin pulses at N+6; words_written=4.
- Alternating valid (toggle every cycle, 6 words): 6 writes, each 2 cycles after its accept, no extra pops, load_fin once.
- Underflow: info FIFO empty while valid=1 for 1 cycle, then 2 normal words.
  - err_underflow=1, and that cycle pops nothing.
  - The 2 normal words write correctly.
- Bad index: entry idx=3 among total 3 → that cycle en=000, err_bad_idx=1, words_written=3, load_fin pulses.
- Zero and overrun:
  - total_words=0 → load_fin next cycle, no pops.
  - total_words=2 with 3 valid words → only 2 pops and writes; the third word is ignored.
- Reset mid-term: assert reset after 2 of 5 words → all outputs 0 asynchronously, FSM in IDLE; a new start(total 1) completes normally.

Source files
------------

// File: rtl/conv_input_word_buf_writer.sv
// ---------------------------------------------------------------------------
// conv_input_word_buf_writer
//
// Takes the 512-bit DDR read-data stream for the conv input-load commands and
// pairs every word with the per-word load-info entry (buffer index, buffer
// address) that the input-load DDR controller queued in the load-info FIFO.
// Each paired word is issued as a single-cycle registered write into the
// selected input row buffer. The block counts words, flags protocol errors
// and pulses load_fin when the programmed number of words has been written.
//
// Pipeline:
//   cycle N   : accept (ddr valid & info available & words still owed),
//               combinational FIFO pop, data captured into stage 1 at edge N
//   cycle N+1 : FIFO dout is valid; stage 2 registers idx/adr/data/enable
//   cycle N+2 : write outputs drive the row buffer for exactly one cycle
//
// Ports:
//   clk                   clock
//   reset                 asynchronous active-low reset
//   start                 one-cycle arm pulse; total_words sampled with it
//   total_words           words expected this term
//   ddr_rd_data           DDR read word
//   ddr_rd_data_valid     ddr_rd_data valid this cycle
//   info_fifo_empty       load-info FIFO empty
//   info_fifo_dout        load-info FIFO output ([31:16] idx, [15:0] adr)
//   info_fifo_rd_en       load-info FIFO pop (combinational)
//   input_word_buf_en_wr  one-hot row-buffer write enable
//   input_word_buf_idx_wr target buffer index
//   input_word_buf_adr_wr target buffer address
//   input_word_buf_wr     write data
//   words_written         words issued this term (saturating)
//   busy                  high in RUN or DRAIN
//   load_fin              one-cycle pulse when the term completes
//   err_underflow         sticky: DDR data arrived while info FIFO empty
//   err_bad_idx           sticky: info entry index out of range
// ---------------------------------------------------------------------------
module conv_input_word_buf_writer #(
  parameter int DATA_W      = 512,
  parameter int BUFFERS_NUM = 3,
  parameter int BUF_IDX_W   = 2,
  parameter int BUF_ADR_W   = 16,
  parameter int INFO_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [15:0]            total_words,
  input  logic [DATA_W-1:0]      ddr_rd_data,
  input  logic                   ddr_rd_data_valid,
  input  logic                   info_fifo_empty,
  input  logic [INFO_W-1:0]      info_fifo_dout,
  output logic                   info_fifo_rd_en,
  output logic [BUFFERS_NUM-1:0] input_word_buf_en_wr,
  output logic [BUF_IDX_W-1:0]   input_word_buf_idx_wr,
  output logic [BUF_ADR_W-1:0]   input_word_buf_adr_wr,
  output logic [DATA_W-1:0]      input_word_buf_wr,
  output logic [15:0]            words_written,
  output logic                   busy,
  output logic                   load_fin,
  output logic                   err_underflow,
  output logic                   err_bad_idx
);

  localparam logic [15:0] BUF_NUM16 = 16'(BUFFERS_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            total_q, total_d;
  logic [15:0]            acc_cnt_q, acc_cnt_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]      s1_data_q, s1_data_d;
  logic [BUFFERS_NUM-1:0] en_q, en_d;
  logic [BUF_IDX_W-1:0]   idx_q, idx_d;
  logic [BUF_ADR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [15:0]            words_q, words_d;
  logic                   err_uf_q, err_uf_d;
  logic                   err_bad_q, err_bad_d;

  logic                   accept;
  logic                   start_ok;
  logic [15:0]            info_idx_full;
  logic [BUF_IDX_W-1:0]   info_idx;
  logic                   idx_ok;
  logic [BUFFERS_NUM-1:0] en_dec;

  // The whole 16-bit index field is range-checked, so stray upper bits are
  // reported as a bad index rather than silently aliased onto a buffer.
  assign info_idx_full = info_fifo_dout[16 +: 16];
  assign info_idx      = info_fifo_dout[16 +: BUF_IDX_W];
  assign idx_ok        = (info_idx_full < BUF_NUM16);

  for (genvar gi = 0; gi < BUFFERS_NUM; gi++) begin : g_en_dec
    assign en_dec[gi] = idx_ok & (info_idx == BUF_IDX_W'(gi));
  end

  assign accept   = (state_q == ST_RUN) & ddr_rd_data_valid & ~info_fifo_empty
                  & (acc_cnt_q < total_q);
  // A new term may only be armed once the previous one has fully drained.
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  always_comb begin
    state_d    = state_q;
    total_d    = total_q;
    acc_cnt_d  = acc_cnt_q;
    s1_valid_d = accept;
    s1_data_d  = s1_data_q;
    en_d       = '0;
    idx_d      = '0;
    adr_d      = '0;
    data_d     = '0;
    words_d    = words_q;
    err_uf_d   = err_uf_q;
    err_bad_d  = err_bad_q;

    if (accept) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
      s1_data_d = ddr_rd_data;
    end

    // Stage 2: FIFO dout belongs to the word sitting in stage 1.
    if (s1_valid_q) begin
      en_d   = en_dec;
      idx_d  = info_idx;
      adr_d  = info_fifo_dout[0 +: BUF_ADR_W];
      data_d = s1_data_q;
      if (words_q != 16'hFFFF) begin
        words_d = words_q + 16'd1;
      end
      if (!idx_ok) begin
        err_bad_d = 1'b1;
      end
    end

    if ((state_q == ST_RUN) && ddr_rd_data_valid && info_fifo_empty) begin
      err_uf_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          total_d   = total_words;
          acc_cnt_d = '0;
          words_d   = '0;
          err_uf_d  = 1'b0;
          err_bad_d = 1'b0;
          state_d   = (total_words == 16'd0) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (acc_cnt_d == total_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // With stage 1 empty the word in stage 2 is the last write; leaving
        // now puts load_fin in the cycle right after that write.
        if (!s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      acc_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      en_q       <= '0;
      idx_q      <= '0;
      adr_q      <= '0;
      data_q     <= '0;
      words_q    <= '0;
      err_uf_q   <= 1'b0;
      err_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      acc_cnt_q  <= acc_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      en_q       <= en_d;
      idx_q      <= idx_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      words_q    <= words_d;
      err_uf_q   <= err_uf_d;
      err_bad_q  <= err_bad_d;
    end
  end

  assign info_fifo_rd_en       = accept;
  assign input_word_buf_en_wr  = en_q;
  assign input_word_buf_idx_wr = idx_q;
  assign input_word_buf_adr_wr = adr_q;
  assign input_word_buf_wr     = data_q;
  assign words_written         = words_q;
  assign busy                  = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign load_fin              = (state_q == ST_DONE);
  assign err_underflow         = err_uf_q;
  assign err_bad_idx           = err_bad_q;

endmodule
